// File: rtl/single_to_int.sv
// rtl/single_to_int.sv - IEEE-754 single-precision to signed 32-bit integer converter
//
// Converts one operand at a time with a bit-serial shifter. Rounding truncates toward zero.
// Out-of-range values and infinities saturate, and NaN returns 0x80000000.
//
// Ports:
//   clk, rstn           clock and asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only while idle
//   a                   single-precision operand, captured on the accept edge
//   out_valid, out_ready result handshake; outputs hold while stalled
//   c                   two's-complement integer result
//   overflow            result saturated (|a| >= 2^31 or infinity)
//   invalid             operand was NaN
//   inexact             nonzero fraction bits were discarded

module single_to_int (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        overflow,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] mag;
  logic [4:0]  count;
  logic        left;
  logic        sign;

  logic [7:0]        exp_f;
  logic [22:0]       man;
  logic signed [8:0] e;
  logic              shift_left;
  logic [4:0]        shift_n;
  logic [31:0]       sat;

  assign exp_f = a[30:23];
  assign man   = a[22:0];
  assign e     = $signed({1'b0, exp_f}) - 9'sd127;
  assign sat   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // The shift path is used only for exponent fields 127..157. There, |e-23| = |exp_f-150| <= 23.
  // Because the result is below 32, working mod 32 on the low five exponent bits is exact.
  // The low five bits of 150 are 22.
  assign shift_left = (exp_f > 8'd150);
  assign shift_n    = shift_left ? (exp_f[4:0] - 5'd22) : (5'd22 - exp_f[4:0]);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      mag      <= '0;
      count    <= '0;
      left     <= 1'b0;
      sign     <= 1'b0;
      c        <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign     <= a[31];
            overflow <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
            if (exp_f == 8'd0) begin
              c       <= '0;
              inexact <= |man;
              state   <= DONE;
            end else if (exp_f == 8'hFF) begin
              if (|man) begin
                c       <= 32'h8000_0000;
                invalid <= 1'b1;
              end else begin
                c        <= sat;
                overflow <= 1'b1;
              end
              state <= DONE;
            end else if (e >= 9'sd31) begin
              // -2^31 is the one representable value in this range.
              if (a == 32'hCF00_0000) begin
                c <= 32'h8000_0000;
              end else begin
                c        <= sat;
                overflow <= 1'b1;
              end
              state <= DONE;
            end else if (e[8]) begin
              c       <= '0;
              inexact <= 1'b1;
              state   <= DONE;
            end else begin
              mag   <= {8'b0, 1'b1, man};
              count <= shift_n;
              left  <= shift_left;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (count != 5'd0) begin
            if (left) begin
              mag <= mag << 1;
            end else begin
              mag <= mag >> 1;
              if (mag[0]) inexact <= 1'b1;
            end
            count <= count - 5'd1;
          end else begin
            c     <= sign ? (~mag + 32'd1) : mag;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
